dqsw_delay_sweep_ctrl: RTL and testbench

Training controller for one LPDDR3 DQSW lane. It drives the delay-line and eye-monitor controls of the lane's DQSW training IOD and consumes that IOD's eye-monitor and out-of-range flags. It sweeps the DQSW delay tap by tap to find the first early-to-late transition, then backs off a fixed number of taps. It reports the found edge tap, or an error, to the lane training sequencer.

---
 rtl/dqsw_delay_sweep_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_dqsw_delay_sweep_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dqsw_delay_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dqsw_delay_sweep_ctrl
// Brief    : DQSW lane training controller. Sweeps the delay line to the first
//            early-to-late transition, then backs off a fixed number of taps.
// Revision : 1.0 - initial release
// ============================================================================
module dqsw_delay_sweep_ctrl #(
   parameter int TAP_W         = 8,
   parameter int MAX_TAPS      = 128,
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLE_CYCLES = 16,
   parameter int BACKOFF_TAPS  = 2
) (
   input  logic             FAB_CLK,
   input  logic             RESET,
   input  logic             START,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERROR,
   output logic [1:0]       ERR_CODE,
   output logic [TAP_W-1:0] EDGE_TAP,
   output logic [TAP_W-1:0] TAP_COUNT,
   output logic             DELAY_LINE_LOAD,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   output logic             EYE_MONITOR_CLEAR_FLAGS,
   input  logic             DELAY_LINE_OUT_OF_RANGE,
   input  logic             EYE_MONITOR_EARLY,
   input  logic             EYE_MONITOR_LATE
);

   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [TAP_W-1:0] c_last_tap    = TAP_W'(MAX_TAPS - 1);
   localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_sample_last = CNT_W'(SAMPLE_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LOAD    = 4'd1,
      S_SETTLE  = 4'd2,
      S_CLEAR   = 4'd3,
      S_SAMPLE  = 4'd4,
      S_EVAL    = 4'd5,
      S_MOVE    = 4'd6,
      S_BACKOFF = 4'd7,
      S_FIN_OK  = 4'd8,
      S_FIN_ERR = 4'd9
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic [TAP_W-1:0] edge_q, edge_d;
   logic [TAP_W-1:0] rem_q, rem_d;
   logic [1:0]       err_q, err_d;
   logic             dir_q, dir_d;
   logic             prev_late_q, prev_late_d;
   logic             late_acc_q, late_acc_d;
   logic             early_acc_q, early_acc_d;
   logic             backoff_q, backoff_d;
   logic             w_busy;
   logic             w_load, w_move, w_clear;

   assign w_busy = (state_q != S_IDLE) && (state_q != S_FIN_OK) && (state_q != S_FIN_ERR);

   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      tap_d       = tap_q;
      edge_d      = edge_q;
      rem_d       = rem_q;
      err_d       = err_q;
      dir_d       = dir_q;
      prev_late_d = prev_late_q;
      late_acc_d  = late_acc_q;
      early_acc_d = early_acc_q;
      backoff_d   = backoff_q;
      w_load      = 1'b0;
      w_move      = 1'b0;
      w_clear     = 1'b0;

      // Out-of-range overrides whatever the current state would do, including any MOVE.
      if (w_busy && DELAY_LINE_OUT_OF_RANGE) begin
         state_d = S_FIN_ERR;
         err_d   = 2'b01;
      end else begin
         case (state_q)
            S_IDLE, S_FIN_OK, S_FIN_ERR: begin
               if (START) begin
                  state_d     = S_LOAD;
                  err_d       = 2'b00;
                  edge_d      = '0;
                  tap_d       = '0;
                  prev_late_d = 1'b0;
                  backoff_d   = 1'b0;
               end
            end
            S_LOAD: begin
               w_load  = 1'b1;
               state_d = S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt_q == c_settle_last) begin
                  state_d = backoff_q ? S_BACKOFF : S_CLEAR;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_CLEAR: begin
               w_clear     = 1'b1;
               late_acc_d  = 1'b0;
               early_acc_d = 1'b0;
               state_d     = S_SAMPLE;
            end
            S_SAMPLE: begin
               late_acc_d  = late_acc_q | EYE_MONITOR_LATE;
               early_acc_d = early_acc_q | EYE_MONITOR_EARLY;
               if (cnt_q == c_sample_last) begin
                  state_d = S_EVAL;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_EVAL: begin
               if ((tap_q != '0) && !prev_late_q && late_acc_q) begin
                  edge_d    = tap_q;
                  backoff_d = 1'b1;
                  rem_d     = (int'(tap_q) < BACKOFF_TAPS) ? tap_q : TAP_W'(BACKOFF_TAPS);
                  state_d   = S_BACKOFF;
               end else if (tap_q == c_last_tap) begin
                  err_d   = 2'b10;
                  state_d = S_FIN_ERR;
               end else begin
                  prev_late_d = late_acc_q;
                  state_d     = S_MOVE;
               end
            end
            S_MOVE: begin
               w_move  = 1'b1;
               dir_d   = 1'b0;
               if (tap_q != c_last_tap) tap_d = tap_q + TAP_W'(1);
               state_d = S_SETTLE;
            end
            S_BACKOFF: begin
               if (rem_q == '0) begin
                  state_d = S_FIN_OK;
               end else begin
                  w_move  = 1'b1;
                  dir_d   = 1'b1;
                  if (tap_q != '0) tap_d = tap_q - TAP_W'(1);
                  rem_d   = rem_q - TAP_W'(1);
                  state_d = S_SETTLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         tap_q       <= '0;
         edge_q      <= '0;
         rem_q       <= '0;
         err_q       <= 2'b00;
         dir_q       <= 1'b0;
         prev_late_q <= 1'b0;
         late_acc_q  <= 1'b0;
         early_acc_q <= 1'b0;
         backoff_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tap_q       <= tap_d;
         edge_q      <= edge_d;
         rem_q       <= rem_d;
         err_q       <= err_d;
         dir_q       <= dir_d;
         prev_late_q <= prev_late_d;
         late_acc_q  <= late_acc_d;
         early_acc_q <= early_acc_d;
         backoff_q   <= backoff_d;
      end
   end

   assign BUSY                    = w_busy;
   assign DONE                    = (state_q == S_FIN_OK);
   assign ERROR                   = (state_q == S_FIN_ERR);
   assign ERR_CODE                = err_q;
   assign EDGE_TAP                = edge_q;
   assign TAP_COUNT               = tap_q;
   assign DELAY_LINE_LOAD         = w_load;
   assign DELAY_LINE_MOVE         = w_move;
   // dir_d carries the new direction in a MOVE cycle and the held value otherwise.
   assign DELAY_LINE_DIRECTION    = dir_d;
   assign EYE_MONITOR_CLEAR_FLAGS = w_clear;

endmodule
`default_nettype wire

// File: tb/tb_dqsw_delay_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dqsw_delay_sweep_ctrl
// Brief    : Directed bench with an IOD delay-line model and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dqsw_delay_sweep_ctrl;

   localparam int TAP_W   = 8;
   localparam int MAXT    = 16;
   localparam int SETTLE  = 4;
   localparam int SAMPLE  = 8;
   localparam int BACKOFF = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             oor = 1'b0;
   logic             early, late;
   logic             busy, done, error, load, move, dir, clr;
   logic [1:0]       err_code;
   logic [TAP_W-1:0] edge_tap, tap_count;

   dqsw_delay_sweep_ctrl #(
      .TAP_W(TAP_W), .MAX_TAPS(MAXT), .SETTLE_CYCLES(SETTLE),
      .SAMPLE_CYCLES(SAMPLE), .BACKOFF_TAPS(BACKOFF)
   ) dut (
      .FAB_CLK(clk), .RESET(rst), .START(start),
      .BUSY(busy), .DONE(done), .ERROR(error), .ERR_CODE(err_code),
      .EDGE_TAP(edge_tap), .TAP_COUNT(tap_count),
      .DELAY_LINE_LOAD(load), .DELAY_LINE_MOVE(move), .DELAY_LINE_DIRECTION(dir),
      .EYE_MONITOR_CLEAR_FLAGS(clr), .DELAY_LINE_OUT_OF_RANGE(oor),
      .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       done;
      logic       error;
      logic [1:0] code;
      logic [7:0] edge_tap;
      logic [7:0] tap;
      int         inc;
      int         dec;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   late_from = 1000;
   int   iod_tap = 0;
   int   cyc = 0;
   int   inc_cnt = 0, dec_cnt = 0, load_cnt = 0;
   int   last_inc = -1, last_move = -1, last_lm = 0;
   logic last_dir = 1'b0, prev_load = 1'b0;

   // IOD model: the eye reads late once the delay line reaches late_from.
   assign late  = (iod_tap >= late_from);
   assign early = (iod_tap < late_from);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         last_dir = 1'b0;
      end else begin
         if (busy && !load) chk("tap_track", tap_count, iod_tap);
         if (load | move | clr) chk("pulse_excl", int'(load) + int'(move) + int'(clr), 1);
         if (load) begin
            chk("load_width", prev_load, 0);
            load_cnt++;
            inc_cnt = 0; dec_cnt = 0; last_inc = -1; last_move = -1;
            iod_tap = 0; last_lm = cyc;
         end
         if (move) begin
            if (last_move >= 0) chk("move_gap", ((cyc - last_move) >= SETTLE + 1), 1);
            if (!dir) begin
               if (last_inc >= 0) chk("move_period", cyc - last_inc, 15);
               last_inc = cyc; inc_cnt++; iod_tap++;
            end else begin
               dec_cnt++; iod_tap--;
            end
            last_move = cyc; last_lm = cyc; last_dir = dir;
         end else begin
            chk("dir_hold", dir, last_dir);
         end
         if (clr) chk("clear_gap", cyc - last_lm, SETTLE + 1);
      end
      prev_load = load;
   end

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("load_after_start", load, 1);
   endtask

   task automatic wait_end();
      bit seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done | error) begin seen = 1'b1; break; end
      end
      chk("sweep_end_seen", seen, 1);
   endtask

   task automatic check_result();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("done", done, e.done);
         chk("error", error, e.error);
         chk("err_code", err_code, e.code);
         chk("edge_tap", edge_tap, e.edge_tap);
         chk("tap_count", tap_count, e.tap);
         chk("inc_moves", inc_cnt, e.inc);
         chk("dec_moves", dec_cnt, e.dec);
         chk("busy_end", busy, 0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_err_code"}, err_code, 0);
      chk({tag, "_edge_tap"}, edge_tap, 0);
      chk({tag, "_tap_count"}, tap_count, 0);
      chk({tag, "_pulses"}, {load, move, clr}, 0);
      chk({tag, "_dir"}, dir, 0);
   endtask

   initial begin
      int loads0;
      bit hit;

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // Edge at tap 5: back off two taps to tap 3.
      late_from = 5;
      sb.push_back('{1'b1, 1'b0, 2'b00, 8'd5, 8'd3, 5, 2});
      do_start(); wait_end(); check_result();
      repeat (5) @(negedge clk);
      chk("done_held", done, 1);

      // Edge at tap 1: backoff clamps to a single tap.
      late_from = 1;
      sb.push_back('{1'b1, 1'b0, 2'b00, 8'd1, 8'd0, 1, 1});
      do_start(); wait_end(); check_result();

      // Late from tap 0: no transition, error at the last tap.
      late_from = 0;
      sb.push_back('{1'b0, 1'b1, 2'b10, 8'd0, 8'd15, 15, 0});
      do_start(); wait_end(); check_result();

      // Out-of-range during SETTLE at tap 7.
      late_from = 1000;
      sb.push_back('{1'b0, 1'b1, 2'b01, 8'd0, 8'd7, 7, 0});
      do_start();
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (tap_count == 8'd7) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      chk("reached_tap7", hit, 1);
      oor = 1'b1;
      @(negedge clk);
      oor = 1'b0;
      check_result();
      repeat (40) @(negedge clk);
      chk("oor_no_more_moves", inc_cnt + dec_cnt, 7);
      chk("oor_tap_hold", tap_count, 7);
      chk("oor_error_held", error, 1);

      // START while busy is ignored.
      late_from = 3;
      sb.push_back('{1'b1, 1'b0, 2'b00, 8'd3, 8'd1, 3, 2});
      loads0 = load_cnt;
      do_start();
      repeat (20) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (30) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_end(); check_result();
      chk("single_load", load_cnt - loads0, 1);

      // RESET mid-SAMPLE aborts; a fresh START runs a full sweep.
      late_from = 5;
      do_start();
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (clr) begin hit = 1'b1; break; end
      end
      chk("clear_seen", hit, 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_all_zero("abort");
      chk("sb_empty_after_abort", sb.size(), 0);
      sb.push_back('{1'b1, 1'b0, 2'b00, 8'd5, 8'd3, 5, 2});
      do_start(); wait_end(); check_result();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
